lsu: RTL and testbench
======================

# lsu

Load/store unit between the execute stage and the writeback result multiplexer of the RV32I core. Converts a memory instruction (funct3, address, store data) into a word-aligned, byte-enabled data-memory request with a ready handshake, and stalls the pipeline while the access is outstanding. Returns sign- or zero-extended load data on the "memory data" input of the writeback mux. Flags misaligned or illegal accesses.

## Interface
- No parameters. Data and address paths are fixed at 32 bits.

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  memory instruction present in execute
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  effective byte address
- req_wdata  in  32  store data (rs2)
- stall  out  1  hold pipeline registers
- load_data  out  32  extended load result to writeback mux
- load_valid  out  1  one-cycle pulse: load_data updated
- lsu_err  out  1  one-cycle pulse: misaligned or illegal access
- mem_req  out  1  data-memory request
- mem_we  out  1  write strobe
- mem_addr  out  32  word address (bits [1:0] = 0)
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ready  in  1  memory accepted/completed the request this cycle
- mem_rdata  in  32  read word, valid when mem_ready=1 on a load

## Operation
- FSM states: IDLE, BUSY, DONE. Reset → IDLE. All registered outputs are 0 after reset. load_data resets to 0x00000000.
- IDLE: if req_valid=1 and access is legal, latch we, funct3, addr[1:0], mem_addr, mem_be, mem_wdata; go to BUSY. If req_valid=1 and access is illegal, pulse lsu_err next cycle, stay IDLE, no memory request.
- Illegal: funct3 ∈ {011, 110, 111}; stores with funct3 100 or 101; misaligned H/HU (addr[0]=1) or W (addr[1:0]≠0) when MISALIGN_TRAP_EN is defined.
- BUSY: mem_req=1. mem_we, mem_addr, mem_be, mem_wdata are held stable until mem_ready=1. On mem_ready the load result is captured and the FSM goes to DONE.
- DONE: stall=0, mem_req=0. load_valid=1 only for loads. req_valid is ignored because it is still the completed instruction. Go to IDLE.
- stall = (IDLE and req_valid and legal) or BUSY. Combinational.
- Store lanes:
  - SB: mem_be = 4'b0001 << addr[1:0], mem_wdata = {4{wdata[7:0]}}.
  - SH: mem_be = addr[1] ? 1100 : 0011, mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_be = 1111.
- Loads: mem_be is computed the same way. The lane is selected by the latched addr[1:0]. B/H are sign-extended and BU/HU are zero-extended.
- load_data holds its value until the next load completes. Stores and errors do not alter it.
- rst in any state → IDLE next edge. mem_req drops and the outstanding access is abandoned.

## Timing
- Accept cycle T0 (IDLE, stall=1). mem_req is first high at T1.
- mem_ready at T1 gives DONE at T2. load_valid and load_data are valid at T2, and stall=0 at T2. Minimum occupancy is 3 cycles (T0–T2). Each cycle mem_ready stays low adds one BUSY cycle.
- lsu_err is asserted in the cycle after the illegal request is seen. stall=0 during the request cycle.
- mem_ready is ignored outside BUSY.

## Configuration
- MISALIGN_TRAP_EN defined: misaligned H/HU/W accesses raise lsu_err and generate no memory request.
- MISALIGN_TRAP_EN undefined: misaligned accesses proceed with the address aligned down to the access size.
  - Halfword: addr[0] treated as 0. Word: addr[1:0] treated as 0.
  - lsu_err flags only illegal funct3 / store-funct3 combinations.

## Test plan
- LW addr 0x1000, mem_ready at T1, mem_rdata 0xDEADBEEF → mem_be=1111, mem_addr=0x1000, load_valid at T2, load_data=0xDEADBEEF, stall high T0–T1 only.
- LB addr 0x1003, mem_rdata 0x80123456 → load_data=0xFFFFFF80. LBU at the same address → 0x00000080. LHU addr 0x1002 → 0x00008012.
- SH addr 0x2002, req_wdata 0x1234ABCD → mem_we=1, mem_addr=0x2000, mem_be=1100, mem_wdata=0xABCDABCD. No load_valid, load_data unchanged.
- mem_ready held low for 3 cycles → stall=1 and all mem_* stable throughout. Completes 1 cycle after mem_ready.
- With MISALIGN_TRAP_EN: LW addr 0x1001 → lsu_err pulse, mem_req never set, stall=0. Without it: the access goes to 0x1000 with no error. funct3=011 gives lsu_err in both builds.
- rst asserted in BUSY → next cycle IDLE, mem_req=0, stall=0, load_data=0.

Source files
------------

// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_if : bundle of the request, writeback and data-memory signals of the
//          load/store unit.
//
// Handshake: the execute stage holds req_* stable while req_valid=1 and
// stall=1. The memory side sees a request while mem_req=1. mem_we, mem_addr,
// mem_be and mem_wdata stay stable until the memory answers with mem_ready=1.
// On a load, mem_rdata is sampled in that same cycle. load_valid and lsu_err
// are single-cycle pulses with no back-pressure.
//
// Modports
//   slave  : the LSU (consumes req_*/mem_ready/mem_rdata, drives the rest)
//   master : the pipeline/memory environment around the LSU
// ---------------------------------------------------------------------------
interface lsu_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        lsu_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_ready, mem_rdata,
    output stall, load_data, load_valid, lsu_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_ready, mem_rdata,
    input  stall, load_data, load_valid, lsu_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu : RV32I load/store unit.
//
// Turns a memory instruction into a word-aligned, byte-enabled data-memory
// request. The pipeline is stalled while the access is outstanding. Load data
// is returned sign- or zero-extended, and illegal accesses are flagged.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   io_bus       lsu_if.slave  (request, writeback and memory signals)
//   o_dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Build option
//   MISALIGN_TRAP_EN : when defined, misaligned H/HU/W accesses raise lsu_err
//                      and are dropped. When undefined, they are aligned
//                      down to the access size and proceed.
// ---------------------------------------------------------------------------
module lsu (
  input  logic        clk,
  input  logic        rst,
  lsu_if.slave        io_bus,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_load_data;
  logic        r_err;

  logic        w_f3_bad;
  logic        w_st_bad;
  logic        w_misalign;
  logic        w_legal;
  logic        w_accept;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load_ext;

  // ---------------- request decode ----------------
  always_comb begin
    w_f3_bad   = (io_bus.req_funct3 == 3'b011) || (io_bus.req_funct3 == 3'b110) ||
                 (io_bus.req_funct3 == 3'b111);
    w_st_bad   = io_bus.req_we && ((io_bus.req_funct3 == 3'b100) ||
                                   (io_bus.req_funct3 == 3'b101));
    // funct3[1:0] is the access size for every legal encoding: 00 B, 01 H, 10 W.
    w_misalign = ((io_bus.req_funct3[1:0] == 2'b01) && io_bus.req_addr[0]) ||
                 ((io_bus.req_funct3[1:0] == 2'b10) && (io_bus.req_addr[1:0] != 2'b00));
`ifdef MISALIGN_TRAP_EN
    w_legal    = !w_f3_bad && !w_st_bad && !w_misalign;
`else
    w_legal    = !w_f3_bad && !w_st_bad;
`endif
    w_accept   = (r_state == S_IDLE) && io_bus.req_valid && w_legal;

    // Byte offset is aligned down to the access size, so an untrapped
    // misaligned access lands on the naturally aligned container.
    w_off   = 2'b00;
    w_be    = 4'b0000;
    w_wdata = io_bus.req_wdata;
    case (io_bus.req_funct3[1:0])
      2'b00: begin
        w_off   = io_bus.req_addr[1:0];
        w_be    = 4'b0001 << io_bus.req_addr[1:0];
        w_wdata = {4{io_bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_off   = {io_bus.req_addr[1], 1'b0};
        w_be    = io_bus.req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{io_bus.req_wdata[15:0]}};
      end
      2'b10: begin
        w_off   = 2'b00;
        w_be    = 4'b1111;
        w_wdata = io_bus.req_wdata;
      end
      default: begin
        w_off   = 2'b00;
        w_be    = 4'b0000;
        w_wdata = io_bus.req_wdata;
      end
    endcase
  end

  // ---------------- load lane select and extension ----------------
  always_comb begin
    w_shifted  = io_bus.mem_rdata >> {r_off, 3'b000};
    w_load_ext = w_shifted;
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load_ext = {24'h000000, w_shifted[7:0]};
      3'b001:  w_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load_ext = {16'h0000, w_shifted[15:0]};
      default: w_load_ext = io_bus.mem_rdata;
    endcase
  end

  // ---------------- FSM next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_BUSY;
      S_BUSY:  if (io_bus.mem_ready) w_next = S_DONE;
      // req_valid is still the completed instruction here, so it is ignored.
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- state and datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_addr      <= 32'h0;
      r_be        <= 4'b0000;
      r_wdata     <= 32'h0;
      r_load_data <= 32'h0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= (r_state == S_IDLE) && io_bus.req_valid && !w_legal;
      if (w_accept) begin
        r_we     <= io_bus.req_we;
        r_funct3 <= io_bus.req_funct3;
        r_off    <= w_off;
        r_addr   <= {io_bus.req_addr[31:2], 2'b00};
        r_be     <= w_be;
        r_wdata  <= w_wdata;
      end
      if ((r_state == S_BUSY) && io_bus.mem_ready && !r_we) begin
        r_load_data <= w_load_ext;
      end
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    io_bus.stall      = w_accept || (r_state == S_BUSY);
    io_bus.mem_req    = (r_state == S_BUSY);
    io_bus.mem_we     = r_we && (r_state == S_BUSY);
    io_bus.mem_addr   = r_addr;
    io_bus.mem_be     = r_be;
    io_bus.mem_wdata  = r_wdata;
    io_bus.load_valid = (r_state == S_DONE) && !r_we;
    io_bus.load_data  = r_load_data;
    io_bus.lsu_err    = r_err;
    o_dbg_state       = r_state;
  end

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu : directed bench for lsu with a scoreboard. The driver pushes the
// expected memory request, load result or error into queues. Monitors pop
// and compare them when the DUT presents mem_ready, load_valid or lsu_err.
// ---------------------------------------------------------------------------
module tb_lsu;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  dbg_state;

  lsu_if bus ();

  lsu dut (
    .clk         (clk),
    .rst         (rst),
    .io_bus      (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  mem_exp_t    mem_q[$];
  logic [31:0] err_q[$];
  logic [31:0] last_load;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: memory request at the accepting cycle
  always @(negedge clk) begin
    if (!rst && bus.mem_req && bus.mem_ready) begin
      if (mem_q.size() == 0) begin
        chk("mem_unexpected_req", 32'd1, 32'd0);
      end else begin
        mem_exp_t e;
        e = mem_q.pop_front();
        chk("mem_we",    {31'd0, bus.mem_we}, {31'd0, e.we});
        chk("mem_addr",  bus.mem_addr, e.addr);
        chk("mem_be",    {28'd0, bus.mem_be}, {28'd0, e.be});
        chk("mem_wdata", bus.mem_wdata, e.wdata);
      end
    end
  end

  // monitor: load result
  always @(negedge clk) begin
    if (!rst && bus.load_valid) begin
      if (exp_q.size() == 0) chk("load_unexpected", 32'd1, 32'd0);
      else chk("load_data", bus.load_data, exp_q.pop_front());
    end
  end

  // monitor: error pulse
  always @(negedge clk) begin
    if (!rst && bus.lsu_err) begin
      if (err_q.size() == 0) chk("err_unexpected", 32'd1, 32'd0);
      else chk("err_addr_seen", bus.req_addr, err_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input logic [31:0] e_load);
    mem_exp_t e;
    e.we = we; e.addr = e_addr; e.be = e_be; e.wdata = e_wdata;
    mem_q.push_back(e);
    if (!we) exp_q.push_back(e_load);
    @(posedge clk); #1;
    drive_req(we, f3, addr, wdata);
    @(negedge clk);
    chk("t0_stall",   {31'd0, bus.stall},   32'd1);
    chk("t0_mem_req", {31'd0, bus.mem_req}, 32'd0);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk("wait_stall",     {31'd0, bus.stall},   32'd1);
      chk("wait_mem_req",   {31'd0, bus.mem_req}, 32'd1);
      chk("wait_mem_addr",  bus.mem_addr,  e_addr);
      chk("wait_mem_be",    {28'd0, bus.mem_be}, {28'd0, e_be});
      chk("wait_mem_wdata", bus.mem_wdata, e_wdata);
      chk("wait_mem_we",    {31'd0, bus.mem_we}, {31'd0, we});
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rdata;
    @(negedge clk);
    chk("t1_stall", {31'd0, bus.stall}, 32'd1);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = $urandom;
    @(negedge clk);
    chk("t2_stall",   {31'd0, bus.stall},   32'd0);
    chk("t2_mem_req", {31'd0, bus.mem_req}, 32'd0);
    if (we) begin
      chk("store_no_load_valid",   {31'd0, bus.load_valid}, 32'd0);
      chk("store_keeps_load_data", bus.load_data, last_load);
    end else begin
      last_load = e_load;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("back_to_idle", {30'd0, dbg_state}, 32'd0);
  endtask

  task automatic bad_access(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    err_q.push_back(addr);
    @(posedge clk); #1;
    drive_req(we, f3, addr, 32'h5555AAAA);
    @(negedge clk);
    chk("err_req_stall",   {31'd0, bus.stall},   32'd0);
    chk("err_req_mem_req", {31'd0, bus.mem_req}, 32'd0);
    // keep req_addr visible in the pulse cycle so the monitor can tag it
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("err_pulse",      {31'd0, bus.lsu_err}, 32'd1);
    chk("err_no_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("err_keeps_load", bus.load_data, last_load);
    @(posedge clk); #1;
    bus.req_addr = 32'h0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_fail = 0; last_load = 32'h0;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall",      {31'd0, bus.stall},      32'd0);
    chk("rst_mem_req",    {31'd0, bus.mem_req},    32'd0);
    chk("rst_load_data",  bus.load_data,           32'h0);
    chk("rst_load_valid", {31'd0, bus.load_valid}, 32'd0);
    chk("rst_lsu_err",    {31'd0, bus.lsu_err},    32'd0);
    chk("rst_state",      {30'd0, dbg_state},      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    //     we  f3      addr          wdata         rdata         w  e_addr        e_be     e_wdata       e_load
    access(0, 3'b010, 32'h0000_1000, 32'h0,        32'hDEADBEEF, 0, 32'h0000_1000, 4'b1111, 32'h0,        32'hDEADBEEF);
    access(0, 3'b000, 32'h0000_1003, 32'h0,        32'h80123456, 0, 32'h0000_1000, 4'b1000, 32'h0,        32'hFFFFFF80);
    access(0, 3'b100, 32'h0000_1003, 32'h0,        32'h80123456, 1, 32'h0000_1000, 4'b1000, 32'h0,        32'h00000080);
    access(0, 3'b101, 32'h0000_1002, 32'h0,        32'h80123456, 0, 32'h0000_1000, 4'b1100, 32'h0,        32'h00008012);
    access(0, 3'b001, 32'h0000_1000, 32'h0,        32'h0000F00D, 0, 32'h0000_1000, 4'b0011, 32'h0,        32'hFFFFF00D);
    access(1, 3'b001, 32'h0000_2002, 32'h1234ABCD, 32'h0,        0, 32'h0000_2000, 4'b1100, 32'hABCDABCD, 32'h0);
    access(1, 3'b000, 32'h0000_3001, 32'h000000A5, 32'h0,        3, 32'h0000_3000, 4'b0010, 32'hA5A5A5A5, 32'h0);
    access(1, 3'b010, 32'h0000_3004, 32'hCAFEF00D, 32'h0,        0, 32'h0000_3004, 4'b1111, 32'hCAFEF00D, 32'h0);
    access(0, 3'b000, 32'h0000_4001, 32'h0,        32'h00007F00, 0, 32'h0000_4000, 4'b0010, 32'h0,        32'h0000007F);

`ifdef MISALIGN_TRAP_EN
    bad_access(0, 3'b010, 32'h0000_1001);
    bad_access(0, 3'b001, 32'h0000_1003);
`else
    access(0, 3'b010, 32'h0000_1001, 32'h0,        32'h11223344, 0, 32'h0000_1000, 4'b1111, 32'h0,        32'h11223344);
    access(0, 3'b001, 32'h0000_1003, 32'h0,        32'h80123456, 0, 32'h0000_1000, 4'b1100, 32'h0,        32'hFFFF8012);
`endif
    bad_access(0, 3'b011, 32'h0000_5000);
    bad_access(1, 3'b100, 32'h0000_5004);
    bad_access(0, 3'b111, 32'h0000_5008);

    // reset while BUSY abandons the access and clears load_data
    @(posedge clk); #1;
    drive_req(0, 3'b010, 32'h0000_6000, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_before_rst", {30'd0, dbg_state}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_state",     {30'd0, dbg_state},   32'd0);
    chk("post_rst_mem_req",   {31'd0, bus.mem_req}, 32'd0);
    chk("post_rst_stall",     {31'd0, bus.stall},   32'd0);
    chk("post_rst_load_data", bus.load_data,        32'h0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("exp_q_drained",   exp_q.size(), 32'd0);
    chk("mem_q_drained",   mem_q.size(), 32'd0);
    chk("err_q_drained",   err_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
